// File: rtl/ringmult_axis_pkg.sv
// Shared types and constants for the ring-multiplier AXI4-Stream front end.
package ringmult_axis_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pkt_state_e;

  localparam int unsigned PKT_CNT_W  = 16;
  localparam int unsigned MAX_STRB_W = 128;
  localparam logic [MAX_STRB_W-1:0] TSTRB_ALL_ONES = '1;

endpackage

// File: rtl/axis_sync_fifo.sv
// Register-array synchronous FIFO; push while full and pop while empty are ignored.
module axis_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [$clog2(DEPTH):0]  level_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/axis_coeff_packetizer.sv
// Buffers coefficient words and emits them as fixed-length AXI4-Stream packets;
// a flush request drains a partial packet.
module axis_coeff_packetizer
  import ringmult_axis_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned PACKET_LEN = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     in_data,
  output logic                      in_ready,
  input  logic                      flush,
  input  logic                      clr_ovf,
  output logic                      M_AXIS_TVALID,
  output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_TSTRB,
  output logic                      M_AXIS_TLAST,
  input  logic                      M_AXIS_TREADY,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow,
  output logic [PKT_CNT_W-1:0]      pkt_count,
  output logic                      busy
);

  localparam int unsigned LW     = $clog2(DEPTH) + 1;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  pkt_state_e           state_q, state_d;
  logic [LW-1:0]        beats_left_q, beats_left_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic                 overflow_q, overflow_d;
  logic                 flush_pending_q, flush_pending_d;

  logic                  fifo_full, fifo_empty, push, pop;
  logic [LW-1:0]         fifo_level;
  logic [DATA_WIDTH-1:0] fifo_head;

  assign push = in_valid && !fifo_full;
  assign pop  = (state_q == ST_SEND) && M_AXIS_TREADY;

  axis_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .rdata_o (fifo_head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d         = state_q;
    beats_left_d    = beats_left_q;
    pkt_count_d     = pkt_count_q;
    flush_pending_d = flush_pending_q || flush;
    overflow_d      = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    // A dropped word outranks a same-cycle clear.
    if (in_valid && fifo_full) overflow_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fifo_level >= LW'(PACKET_LEN)) begin
          state_d      = ST_SEND;
          beats_left_d = LW'(PACKET_LEN);
        end else if (flush_pending_q) begin
          // Consume the request; a new pulse this cycle stays latched.
          flush_pending_d = flush;
          if (fifo_level != '0) begin
            state_d      = ST_SEND;
            beats_left_d = fifo_level;
          end
        end
      end
      ST_SEND: begin
        if (pop) begin
          beats_left_d = beats_left_q - LW'(1);
          if (beats_left_q == LW'(1)) begin
            pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q         <= ST_IDLE;
      beats_left_q    <= '0;
      pkt_count_q     <= '0;
      overflow_q      <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      beats_left_q    <= beats_left_d;
      pkt_count_q     <= pkt_count_d;
      overflow_q      <= overflow_d;
      flush_pending_q <= flush_pending_d;
    end
  end

  assign in_ready      = !fifo_full;
  assign M_AXIS_TVALID = (state_q == ST_SEND);
  assign M_AXIS_TDATA  = fifo_head;
  assign M_AXIS_TLAST  = (state_q == ST_SEND) && (beats_left_q == LW'(1));
  assign M_AXIS_TSTRB  = TSTRB_ALL_ONES[STRB_W-1:0];
  assign level         = fifo_level;
  assign overflow      = overflow_q;
  assign pkt_count     = pkt_count_q;
  assign busy          = (state_q == ST_SEND);

endmodule
